// File: rtl/music_play_ctrl.sv
// music_play_ctrl: walks a song ROM, holds each note for its beat count and
// inserts a silent articulation gap before the next entry.
//
// state | meaning
// IDLE  | stopped, rom_addr parked at 0
// LOAD  | one cycle: latch rom_data and decide note / end-of-song
// NOTE  | tone enabled, counting down the audible part of the entry
// GAP   | tone disabled, counting down the articulation gap
// PAUSE | counter and note frozen, resumes into the remembered state
module music_play_ctrl #(
    parameter int BEAT_CYCLES = 1_250_000,
    parameter int GAP_CYCLES  = 125_000,
    parameter int ADDR_W      = 6,
    parameter int NOTE_W      = 5,
    parameter int DUR_W       = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    play_tog,
    input  logic                    next,
    input  logic                    prev,
    input  logic                    loop_en,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic [NOTE_W-1:0]       note,
    output logic                    note_valid,
    output logic                    playing
);

    localparam int CNT_W = $clog2((2**DUR_W - 1) * BEAT_CYCLES);
    localparam logic [CNT_W-1:0] BEAT_C  = CNT_W'(BEAT_CYCLES);
    localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {IDLE, LOAD, NOTE, GAP, PAUSE} state_t;

    state_t            state;
    state_t            resume_state;
    logic [CNT_W-1:0]  cnt;

    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;
    logic [CNT_W-1:0]  note_load;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] addr_dec;

    state_t            adv_state;
    logic [CNT_W-1:0]  adv_cnt;
    logic [ADDR_W-1:0] adv_addr;

    assign rom_note  = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur   = rom_data[DUR_W-1:0];
    assign note_load = CNT_W'(rom_dur) * BEAT_C - GAP_C - CNT_ONE;
    assign addr_inc  = rom_addr + ADDR_ONE;
    assign addr_dec  = (rom_addr == '0) ? '0 : rom_addr - ADDR_ONE;

    // Outputs decode straight from the registered state, so buttons never
    // reach them combinationally.
    assign note_valid = (state == NOTE);
    assign playing    = (state == LOAD) || (state == NOTE) || (state == GAP);

    // Where NOTE/GAP would go this cycle if nothing were pressed. A pause
    // stores this outcome so the pause-request cycle still counts as played.
    always_comb begin
        adv_state = state;
        adv_cnt   = cnt - CNT_ONE;
        adv_addr  = rom_addr;
        if (cnt == '0) begin
            if (state == NOTE) begin
                adv_state = GAP;
                adv_cnt   = GAP_C - CNT_ONE;
            end else begin
                adv_state = LOAD;
                adv_cnt   = cnt;
                adv_addr  = addr_inc;
            end
        end
    end

    // Sequencer FSM with beat down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            resume_state <= IDLE;
            cnt          <= '0;
            rom_addr     <= '0;
            note         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (play_tog) state <= LOAD;
                end
                LOAD: begin
                    if (rom_dur != '0) begin
                        note  <= rom_note;
                        cnt   <= note_load;
                        state <= NOTE;
                    end else if (rom_addr == '0) begin
                        state <= IDLE;
                    end else begin
                        rom_addr <= '0;
                        state    <= loop_en ? LOAD : IDLE;
                    end
                end
                NOTE, GAP: begin
                    if (play_tog) begin
                        state        <= PAUSE;
                        resume_state <= adv_state;
                        cnt          <= adv_cnt;
                        rom_addr     <= adv_addr;
                    end else if (next) begin
                        rom_addr <= addr_inc;
                        state    <= LOAD;
                    end else if (prev) begin
                        rom_addr <= addr_dec;
                        state    <= LOAD;
                    end else begin
                        state    <= adv_state;
                        cnt      <= adv_cnt;
                        rom_addr <= adv_addr;
                    end
                end
                PAUSE: begin
                    if (play_tog) begin
                        state <= resume_state;
                    end else if (next) begin
                        rom_addr <= addr_inc;
                        state    <= LOAD;
                    end else if (prev) begin
                        rom_addr <= addr_dec;
                        state    <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_music_play_ctrl.sv
// Directed bench for music_play_ctrl with a tiny three-entry song ROM.
module tb_music_play_ctrl;

    logic       clk;
    logic       rst_n;
    logic       play_tog;
    logic       next;
    logic       prev;
    logic       loop_en;
    logic [2:0] rom_addr;
    logic [7:0] rom_data;
    logic [4:0] note;
    logic       note_valid;
    logic       playing;
    logic       empty_rom;

    int n_cmp = 0;
    int n_err = 0;

    music_play_ctrl #(
        .BEAT_CYCLES(10),
        .GAP_CYCLES (2),
        .ADDR_W     (3),
        .NOTE_W     (5),
        .DUR_W      (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .play_tog  (play_tog),
        .next      (next),
        .prev      (prev),
        .loop_en   (loop_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .note      (note),
        .note_valid(note_valid),
        .playing   (playing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // song ROM: {note, dur}
    always_comb begin
        rom_data = 8'h00;
        case (rom_addr)
            3'd0:    rom_data = empty_rom ? 8'h00 : {5'd5, 3'd2};
            3'd1:    rom_data = {5'd9, 3'd1};
            default: rom_data = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic pulse_play();
        play_tog = 1'b1;
        tick();
        play_tog = 1'b0;
    endtask

    task automatic count_high(output int n);
        n = 0;
        while (note_valid === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic count_gap(input logic [2:0] a, output int n);
        n = 0;
        while (note_valid === 1'b0 && playing === 1'b1 && rom_addr === a && n < 200) begin
            n++;
            tick();
        end
    endtask

    // Called in the LOAD cycle of an entry; leaves the bench in the next LOAD.
    task automatic play_entry(input logic [2:0] a, input logic [4:0] nt, input int hi);
        int n;
        check($sformatf("load_addr%0d", a), rom_addr, a);
        check($sformatf("load_playing%0d", a), playing, 1);
        check($sformatf("load_nv%0d", a), note_valid, 0);
        tick();
        check($sformatf("note_at%0d", a), note, nt);
        count_high(n);
        check($sformatf("high_len%0d", a), n, hi);
        count_gap(a, n);
        check($sformatf("gap_len%0d", a), n, 2);
    endtask

    initial begin
        int n;
        int bad;
        rst_n = 1'b0; play_tog = 1'b0; next = 1'b0; prev = 1'b0;
        loop_en = 1'b0; empty_rom = 1'b0;
        #12;
        check("rst_addr", rom_addr, 0);
        check("rst_note", note, 0);
        check("rst_nv", note_valid, 0);
        check("rst_playing", playing, 0);
        rst_n = 1'b1;
        tick();

        // next/prev ignored in IDLE
        next = 1'b1; tick(); next = 1'b0;
        prev = 1'b1; tick(); prev = 1'b0;
        check("idle_next_addr", rom_addr, 0);
        check("idle_next_playing", playing, 0);

        // play through, no loop
        pulse_play();
        play_entry(3'd0, 5'd5, 18);
        play_entry(3'd1, 5'd9, 8);
        check("end_load_addr", rom_addr, 2);
        check("end_load_playing", playing, 1);
        tick();
        check("end_idle_addr", rom_addr, 0);
        check("end_idle_playing", playing, 0);
        repeat (3) tick();
        check("end_idle_stays", playing, 0);

        // looping
        loop_en = 1'b1;
        pulse_play();
        play_entry(3'd0, 5'd5, 18);
        play_entry(3'd1, 5'd9, 8);
        check("loop_marker_addr", rom_addr, 2);
        tick();
        play_entry(3'd0, 5'd5, 18);
        loop_en = 1'b0;
        do_reset();

        // pause on 5th NOTE cycle, hold 20 cycles
        pulse_play();
        tick();
        repeat (4) tick();
        check("pre_pause_nv", note_valid, 1);
        pulse_play();
        bad = 0;
        repeat (20) begin
            if (note_valid !== 1'b0) bad++;
            tick();
        end
        check("pause_nv_low", bad, 0);
        check("pause_note_kept", note, 5);
        pulse_play();
        count_high(n);
        check("resume_high", n, 13);
        count_gap(3'd0, n);
        check("resume_gap", n, 2);
        do_reset();

        // next during note 5
        pulse_play();
        tick();
        repeat (2) tick();
        next = 1'b1; tick(); next = 1'b0;
        play_entry(3'd1, 5'd9, 8);
        do_reset();

        // prev at addr0 reloads addr0 in full
        pulse_play();
        tick();
        repeat (3) tick();
        prev = 1'b1; tick(); prev = 1'b0;
        play_entry(3'd0, 5'd5, 18);
        do_reset();

        // play_tog and next together: pause only
        pulse_play();
        tick();
        repeat (2) tick();
        play_tog = 1'b1; next = 1'b1; tick(); play_tog = 1'b0; next = 1'b0;
        check("both_nv", note_valid, 0);
        check("both_playing", playing, 0);
        check("both_addr", rom_addr, 0);
        pulse_play();
        count_high(n);
        check("both_resume_high", n, 15);
        do_reset();

        // empty song
        empty_rom = 1'b1;
        pulse_play();
        check("empty_load", playing, 1);
        tick();
        check("empty_idle", playing, 0);
        bad = 0;
        repeat (10) begin
            if (note_valid !== 1'b0) bad++;
            tick();
        end
        check("empty_nv_never", bad, 0);
        empty_rom = 1'b0;

        // async reset mid-note 9
        pulse_play();
        play_entry(3'd0, 5'd5, 18);
        tick();
        repeat (3) tick();
        check("mid_note_addr", rom_addr, 1);
        rst_n = 1'b0;
        #2;
        check("async_nv", note_valid, 0);
        check("async_playing", playing, 0);
        check("async_note", note, 0);
        check("async_addr", rom_addr, 0);
        #1;
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_rst_idle", playing, 0);
        pulse_play();
        check("post_rst_play", playing, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/music_play_ctrl.md
# music_play_ctrl

Sequencer for the music-player datapath. It walks a song ROM entry by entry, holds each note for its encoded beat count, and inserts an articulation gap between notes. It drives note index and enable to the tone generator. It takes single-cycle, already-synchronized button pulses (play/pause, next, prev) from the button synchronizer/edge-detect stage.

## Interface
- BEAT_CYCLES, 1_250_000: clock cycles per beat; must be greater than GAP_CYCLES.
- GAP_CYCLES, 125_000: silent cycles at the end of every note; must be at least 1.
- ADDR_W, 6: song ROM address width.
- NOTE_W, 5: note index width.
- DUR_W, 3: duration field width, in beats.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- play_tog  in  1  one-cycle pulse; start, pause or resume.
- next  in  1  one-cycle pulse; skip to the following entry.
- prev  in  1  one-cycle pulse; step back one entry.
- loop_en  in  1  level; on end marker, 1 = restart from address 0, 0 = stop.
- rom_addr  out  ADDR_W  song ROM address (registered).
- rom_data  in  NOTE_W+DUR_W  {note, dur}, combinational read of rom_addr; dur==0 is the end-of-song marker.
- note  out  NOTE_W  current note index to the tone generator.
- note_valid  out  1  tone enable.
- playing  out  1  high in LOAD, NOTE and GAP states.

## Operation
- FSM states are IDLE, LOAD, NOTE, GAP and PAUSE.
- IDLE: rom_addr=0 and note_valid=0. play_tog moves to LOAD. next and prev are ignored.
- LOAD (exactly 1 cycle): latch rom_data.
  - dur!=0: note<=rom_data.note, load the down-counter with dur*BEAT_CYCLES-GAP_CYCLES-1, then go to NOTE.
  - dur==0 and rom_addr==0: go to IDLE (empty song).
  - dur==0 and loop_en=1: rom_addr<=0, stay in LOAD.
  - dur==0 and loop_en=0: rom_addr<=0, go to IDLE.
- NOTE: note_valid=1 and the counter decrements. At 0, load GAP_CYCLES-1 and go to GAP.
- GAP: note_valid=0 and the counter decrements. At 0, rom_addr<=rom_addr+1 (wraps at 2^ADDR_W) and go to LOAD.
- play_tog in NOTE/GAP: go to PAUSE, remembering the originating state.
  - The counter and note are frozen; note_valid=0.
  - play_tog in PAUSE returns to the remembered state with the counter unchanged.
- next in NOTE/GAP/PAUSE: rom_addr<=rom_addr+1 (wrapping), go to LOAD.
- prev in NOTE/GAP/PAUSE: rom_addr<=rom_addr-1, saturating at 0, go to LOAD.
- Skipping from PAUSE resumes playback.
- Button priority in a single cycle: play_tog > next > prev. Losing pulses are dropped.
- All button pulses are ignored while in LOAD.
- Counter width: ceil(log2((2^DUR_W-1)*BEAT_CYCLES)) bits. No overflow is permitted.

## Timing
- Reset values: rom_addr=0, note=0, note_valid=0, playing=0, state=IDLE, counter=0.
- Reset takes effect immediately on rst_n low, including mid-note. The first transition occurs on the first rising edge after rst_n goes high.
- All outputs are registered or decoded from registered state. There is no combinational path from buttons to outputs.
- play_tog is sampled at edge k. LOAD occupies cycle k+1. note_valid is high from cycle k+2.
- Per entry: 1 LOAD cycle, then dur*BEAT_CYCLES-GAP_CYCLES NOTE cycles, then GAP_CYCLES GAP cycles. Total is dur*BEAT_CYCLES+1 cycles.
- Pause/resume takes 1 cycle each way. note_valid drops the cycle after the pulse is sampled. No NOTE cycles are lost or added across a pause.
- rom_data must be stable during the LOAD cycle. The ROM is read only in LOAD.

## Test plan
All scenarios use BEAT_CYCLES=10, GAP_CYCLES=2, ADDR_W=3. ROM contents: addr0={5,2}, addr1={9,1}, addr2={0,0}.
- Play, loop_en=0:
  - 1 LOAD cycle, then note=5 with note_valid high for 18 cycles, then low for 2 cycles.
  - 1 LOAD cycle, then note=9 high for 8 cycles, then low for 2 cycles.
  - Then LOAD at addr2, then IDLE with rom_addr=0 and playing=0.
- loop_en=1: after the addr2 marker, rom_addr returns to 0 and note=5 plays again for 18 cycles, indefinitely.
- Pause on the 5th NOTE cycle of note 5, hold 20 cycles, then play_tog again:
  - note_valid is 0 throughout the pause.
  - After resume, 13 remaining high cycles, then the 2-cycle gap.
- Skips:
  - next during note 5: LOAD with rom_addr=1, then note=9 for 8 cycles.
  - prev at addr0: reload addr0, full 18-cycle note 5.
  - play_tog and next in the same cycle: PAUSE only, rom_addr unchanged.
- Empty ROM (addr0 dur=0): play_tog gives 1 LOAD cycle then IDLE; note_valid never asserts.
- rst_n low mid-note: note_valid, playing, note and rom_addr go to 0 immediately without a clock edge. After release, the block stays in IDLE until play_tog.
